temp_bcd_conv: RTL and testbench

- Converts a raw two's-complement temperature word (DS18B20 format, 1/16 °C per LSB) into three BCD digits: tens of °C, units of °C, tenths of °C.
- Sits directly upstream of the UART temperature sender and drives its `temp_hun` / `temp_ten` / `temp_unit` / `temp_upen` inputs.
- Uses a scale stage followed by a sequential double-dabble.
- Output range is clamped to 00.0 … 99.9 °C, with over/under flags.

---
 rtl/temp_bcd_conv.sv | 157 +++++++++++++++
 tb/tb_temp_bcd_conv.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_bcd_conv.sv
// Raw DS18B20 temperature to three BCD digits (tens/units/tenths of degC).
// Define TEMP_ROUND_EN to round half-up to 0.1 degC; otherwise truncate.
module temp_bcd_conv #(
  parameter int RAW_W     = 12,
  parameter int FRAC_BITS = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             raw_valid,
  input  logic [RAW_W-1:0] raw_temp,
  output logic             conv_busy,
  output logic             conv_done,
  output logic             temp_upen,
  output logic [3:0]       temp_hun,
  output logic [3:0]       temp_ten,
  output logic [3:0]       temp_unit,
  output logic             temp_over,
  output logic             temp_under
);

  localparam int SW = RAW_W + 4;

`ifdef TEMP_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(8);
`else
  localparam logic [SW-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCALE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_nxt;
  logic   accept;

  logic [RAW_W-1:0] raw_q;
  logic [9:0]       bin_q;
  logic [11:0]      bcd_q;
  logic [3:0]       cnt_q;
  logic             over_q;
  logic             under_q;

  logic [SW-1:0] mag;
  logic [SW-1:0] prod;
  logic [SW-1:0] tenths;
  logic [9:0]    val;
  logic          sc_over;
  logic          sc_under;
  logic [11:0]   bcd_adj;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // DONE doubles as an accept slot so back-to-back samples run every 12 cycles
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (raw_valid) begin
          accept    = 1'b1;
          state_nxt = S_SCALE;
        end
      end
      S_SCALE: state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (cnt_q == 4'd9) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (raw_valid) begin
          accept    = 1'b1;
          state_nxt = S_SCALE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mag      = SW'(raw_q);
    prod     = (mag << 3) + (mag << 1) + RND;
    tenths   = prod >> FRAC_BITS;
    val      = tenths[9:0];
    sc_over  = 1'b0;
    sc_under = 1'b0;
    if (raw_q[RAW_W-1]) begin
      val      = '0;
      sc_under = 1'b1;
    end else if (tenths > SW'(999)) begin
      val     = 10'd999;
      sc_over = 1'b1;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      raw_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      over_q     <= 1'b0;
      under_q    <= 1'b0;
      conv_busy  <= 1'b0;
      conv_done  <= 1'b0;
      temp_upen  <= 1'b0;
      temp_hun   <= '0;
      temp_ten   <= '0;
      temp_unit  <= '0;
      temp_over  <= 1'b0;
      temp_under <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      conv_busy <= (state == S_SCALE) || (state == S_SHIFT);
      if (accept) raw_q <= raw_temp;
      unique case (state)
        S_SCALE: begin
          bin_q   <= val;
          bcd_q   <= '0;
          cnt_q   <= '0;
          over_q  <= sc_over;
          under_q <= sc_under;
        end
        S_SHIFT: begin
          bcd_q <= {bcd_adj[10:0], bin_q[9]};
          bin_q <= {bin_q[8:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
        end
        S_DONE: begin
          temp_hun   <= bcd_q[11:8];
          temp_ten   <= bcd_q[7:4];
          temp_unit  <= bcd_q[3:0];
          temp_over  <= over_q;
          temp_under <= under_q;
          conv_done  <= 1'b1;
          temp_upen  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_bcd_conv.sv
// Self-checking bench for temp_bcd_conv: directed corners plus random
// samples against an arithmetic reference model.
module tb_temp_bcd_conv;

  logic        sys_clk;
  logic        sys_rst;
  logic        raw_valid;
  logic [11:0] raw_temp;
  logic        conv_busy;
  logic        conv_done;
  logic        temp_upen;
  logic [3:0]  temp_hun;
  logic [3:0]  temp_ten;
  logic [3:0]  temp_unit;
  logic        temp_over;
  logic        temp_under;

  int tests;
  int fails;

  temp_bcd_conv #(.RAW_W(12), .FRAC_BITS(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .raw_valid (raw_valid),
    .raw_temp  (raw_temp),
    .conv_busy (conv_busy),
    .conv_done (conv_done),
    .temp_upen (temp_upen),
    .temp_hun  (temp_hun),
    .temp_ten  (temp_ten),
    .temp_unit (temp_unit),
    .temp_over (temp_over),
    .temp_under(temp_under)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // {hun, ten, unit, over, under} from plain degC arithmetic
  function automatic logic [13:0] model(input logic [11:0] raw);
    int t;
    int r;
    logic ov;
    logic un;
`ifdef TEMP_ROUND_EN
    r = 8;
`else
    r = 0;
`endif
    ov = 1'b0;
    un = 1'b0;
    if (raw[11]) begin
      t  = 0;
      un = 1'b1;
    end else begin
      t = (int'(raw) * 10 + r) / 16;
      if (t > 999) begin
        t  = 999;
        ov = 1'b1;
      end
    end
    return {4'(t / 100), 4'((t / 10) % 10), 4'(t % 10), ov, un};
  endfunction

  function automatic logic [13:0] outs();
    return {temp_hun, temp_ten, temp_unit, temp_over, temp_under};
  endfunction

  // Called #1 after an edge; strobes one sample and waits (bounded) for done
  task automatic run_conv(input logic [11:0] raw, output int lat,
                          output bit busy_ok, output logic [13:0] res);
    lat     = -1;
    busy_ok = 1'b1;
    res     = '0;
    raw_temp  = raw;
    raw_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    raw_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge sys_clk);
      #1;
      if (conv_done) begin
        lat = i;
        res = outs();
        if (conv_busy) busy_ok = 1'b0;
        break;
      end
      if (!conv_busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    sys_rst   = 1'b1;
    raw_valid = 1'b0;
    raw_temp  = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    tests++;
    if ({conv_busy, conv_done, temp_upen, outs()} !== 17'd0) begin
      fails++;
      $display("FAIL reset_state got=%h want=0",
               {conv_busy, conv_done, temp_upen, outs()});
    end
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_zero_upen();
    int lat;
    bit bok;
    logic [13:0] res;
    tests++;
    if (temp_upen !== 1'b0) begin
      fails++;
      $display("FAIL upen_before got=%b want=0", temp_upen);
    end
    run_conv(12'h000, lat, bok, res);
    tests++;
    if (res !== 14'd0 || lat != 12 || !bok || temp_upen !== 1'b1) begin
      fails++;
      $display("FAIL zero res=%h want=0 lat=%0d bok=%0b upen=%b",
               res, lat, bok, temp_upen);
    end
    repeat (3) @(posedge sys_clk);
    #1;
    tests++;
    if (temp_upen !== 1'b1 || conv_done !== 1'b0) begin
      fails++;
      $display("FAIL upen_hold upen=%b done=%b want 1/0", temp_upen, conv_done);
    end
  endtask

  task automatic test_directed();
    logic [11:0] vec [5];
    int lat;
    bit bok;
    logic [13:0] res;
    vec = '{12'h191, 12'h640, 12'h18F, 12'hFF0, 12'h7FF};
    for (int i = 0; i < 5; i++) begin
      run_conv(vec[i], lat, bok, res);
      tests++;
      if (res !== model(vec[i]) || lat != 12 || !bok) begin
        fails++;
        $display("FAIL directed_%h got=%h want=%h lat=%0d bok=%0b",
                 vec[i], res, model(vec[i]), lat, bok);
      end
      repeat (2) @(posedge sys_clk);
      #1;
      tests++;
      if (outs() !== res || conv_done !== 1'b0) begin
        fails++;
        $display("FAIL hold_%h got=%h want=%h done=%b",
                 vec[i], outs(), res, conv_done);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int ndone;
    int d1;
    int d2;
    logic [13:0] r1;
    logic [13:0] r2;
    ndone = 0;
    d1 = -1;
    d2 = -1;
    r1 = '0;
    r2 = '0;
    raw_temp  = 12'h191;
    raw_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    raw_valid = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      raw_valid = (i == 5) || (i == 12);
      raw_temp  = (i == 5) ? 12'h640 : 12'h18F;
      @(posedge sys_clk);
      #1;
      raw_valid = 1'b0;
      if (conv_done) begin
        ndone++;
        if (d1 < 0) begin d1 = i; r1 = outs(); end
        else begin d2 = i; r2 = outs(); end
      end
    end
    tests++;
    if (ndone != 2 || d1 != 12 || r1 !== model(12'h191)) begin
      fails++;
      $display("FAIL busy_ignore n=%0d d1=%0d r1=%h want 2/12/%h",
               ndone, d1, r1, model(12'h191));
    end
    tests++;
    if (d2 != 24 || r2 !== model(12'h18F)) begin
      fails++;
      $display("FAIL accept_k12 d2=%0d r2=%h want 24/%h",
               d2, r2, model(12'h18F));
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    bit bok;
    bit seen;
    logic [13:0] res;
    raw_temp  = 12'h320;
    raw_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    raw_valid = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    tests++;
    if ({conv_busy, conv_done, temp_upen, outs()} !== 17'd0) begin
      fails++;
      $display("FAIL mid_reset got=%h want=0",
               {conv_busy, conv_done, temp_upen, outs()});
    end
    seen = 1'b0;
    repeat (16) begin
      @(posedge sys_clk);
      #1;
      if (conv_done) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL no_done_after_rst got=%b want=0", seen);
    end
    run_conv(12'h191, lat, bok, res);
    tests++;
    if (res !== model(12'h191) || lat != 12 || !bok) begin
      fails++;
      $display("FAIL post_reset got=%h want=%h lat=%0d", res, model(12'h191), lat);
    end
  endtask

  task automatic test_random();
    logic [11:0] raw;
    int lat;
    bit bok;
    logic [13:0] res;
    for (int n = 0; n < 40; n++) begin
      unique case (n % 3)
        0: raw = 12'($urandom_range(0, 1600));
        1: raw = 12'($urandom_range(1590, 2047));
        default: raw = 12'($urandom_range(0, 4095));
      endcase
      run_conv(raw, lat, bok, res);
      tests++;
      if (res !== model(raw) || lat != 12 || !bok) begin
        fails++;
        $display("FAIL random_%h got=%h want=%h lat=%0d bok=%0b",
                 raw, res, model(raw), lat, bok);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_zero_upen();
    test_directed();
    test_busy_ignore();
    repeat (2) @(posedge sys_clk);
    #1;
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
